rsa_operand_loader: RTL and testbench

// Upstream front end of the RSA encryptor. Accepts a byte stream (valid/ready), assembles the
// 128-bit message, exponent and modulus operands, then sequences the encryptor: a reset pulse,
// a start pulse, and a wait for done with a timeout. Captures the ciphertext and holds it for
// the host, and holds all operands stable for the whole encryption.

---
 rtl/rsa_operand_loader.sv | 175 +++++++++++++++++
 tb/tb_rsa_operand_loader.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rsa_operand_loader.sv
// Byte-stream front end for the RSA encryptor: assembles message/exponent/modulus,
// then sequences encryptor reset, start and a bounded wait for done.
module rsa_operand_loader #(
  parameter int WIDTH   = 128,
  parameter int TIMEOUT = 100000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  output logic [WIDTH-1:0] message,
  output logic [WIDTH-1:0] e_key,
  output logic [WIDTH-1:0] n,
  output logic             enc_reset,
  output logic             enc_start,
  input  logic             enc_done,
  input  logic [WIDTH-1:0] enc_c,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  output logic             busy,
  output logic             error
);

  localparam int BYTES = WIDTH / 8;
  localparam int FRAME = 3 * BYTES;
  localparam int CNT_W = $clog2(FRAME);
  localparam int TO_W  = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] E_FIRST   = CNT_W'(BYTES);
  localparam logic [CNT_W-1:0] N_FIRST   = CNT_W'(2 * BYTES);
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(FRAME - 1);
  localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_LOAD      = 2'd0,
    ST_ENC_RST   = 2'd1,
    ST_ENC_START = 2'd2,
    ST_WAIT_DONE = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] msg_q, msg_d;
  logic [WIDTH-1:0] ekey_q, ekey_d;
  logic [WIDTH-1:0] n_q, n_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             rv_q, rv_d;
  logic             err_q, err_d;
  logic [TO_W-1:0]  tmo_q, tmo_d;
  logic             enc_reset_q, enc_reset_d;
  logic             enc_start_q, enc_start_d;
  logic             busy_q, busy_d;
  logic             in_ready_q, in_ready_d;
  logic             expire_s;

  // Next-state logic: clear overrides everything, including a byte offered in the same cycle
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    msg_d    = msg_q;
    ekey_d   = ekey_q;
    n_d      = n_q;
    result_d = result_q;
    rv_d     = rv_q;
    err_d    = err_q;
    tmo_d    = tmo_q;
    expire_s = 1'b0;

    if (clear) begin
      state_d = ST_LOAD;
      count_d = '0;
    end else begin
      case (state_q)
        ST_LOAD: begin
          if (in_valid && in_ready_q) begin
            rv_d  = (count_q == '0) ? 1'b0 : rv_q;
            err_d = (count_q == '0) ? 1'b0 : err_q;
            if (count_q < E_FIRST) begin
              msg_d = {msg_q[WIDTH-9:0], in_data};
            end else if (count_q < N_FIRST) begin
              ekey_d = {ekey_q[WIDTH-9:0], in_data};
            end else begin
              n_d = {n_q[WIDTH-9:0], in_data};
            end
            if (count_q == LAST_BYTE) begin
              count_d = '0;
              state_d = ST_ENC_RST;
            end else begin
              count_d = count_q + CNT_W'(1);
            end
          end else begin
            state_d = ST_LOAD;
          end
        end
        ST_ENC_RST: begin
          state_d = ST_ENC_START;
        end
        ST_ENC_START: begin
          tmo_d   = '0;
          state_d = ST_WAIT_DONE;
        end
        ST_WAIT_DONE: begin
          tmo_d = tmo_q + TO_W'(1);
          // done on the expiry cycle still counts as a completed encryption
          if (enc_done) begin
            result_d = enc_c;
            rv_d     = 1'b1;
            state_d  = ST_LOAD;
          end else if (tmo_q == TO_LAST) begin
            err_d    = 1'b1;
            expire_s = 1'b1;
            state_d  = ST_LOAD;
          end else begin
            state_d = ST_WAIT_DONE;
          end
        end
        default: begin
          state_d = ST_LOAD;
          count_d = '0;
        end
      endcase
    end

    enc_reset_d = clear | expire_s | (state_d == ST_ENC_RST);
    enc_start_d = (state_d == ST_ENC_START);
    busy_d      = (state_d != ST_LOAD);
    in_ready_d  = (state_d == ST_LOAD);
  end

  // State and output registers; the encryptor is held in reset while reset_n is low
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_LOAD;
      count_q     <= '0;
      msg_q       <= '0;
      ekey_q      <= '0;
      n_q         <= '0;
      result_q    <= '0;
      rv_q        <= 1'b0;
      err_q       <= 1'b0;
      tmo_q       <= '0;
      enc_reset_q <= 1'b1;
      enc_start_q <= 1'b0;
      busy_q      <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      msg_q       <= msg_d;
      ekey_q      <= ekey_d;
      n_q         <= n_d;
      result_q    <= result_d;
      rv_q        <= rv_d;
      err_q       <= err_d;
      tmo_q       <= tmo_d;
      enc_reset_q <= enc_reset_d;
      enc_start_q <= enc_start_d;
      busy_q      <= busy_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign message      = msg_q;
  assign e_key        = ekey_q;
  assign n            = n_q;
  assign enc_reset    = enc_reset_q;
  assign enc_start    = enc_start_q;
  assign result       = result_q;
  assign result_valid = rv_q;
  assign busy         = busy_q;
  assign error        = err_q;

endmodule

// File: tb/tb_rsa_operand_loader.sv
// Randomized bench for rsa_operand_loader: a frame-level reference model plus an
// encryptor stub that computes real modular exponentiation or forced responses.
module tb_rsa_operand_loader;

  localparam int W     = 128;
  localparam int TO    = 50;
  localparam int BYTES = W / 8;
  localparam int FRAME = 3 * BYTES;

  logic         clk      = 1'b0;
  logic         reset_n  = 1'b1;
  logic         clear    = 1'b0;
  logic         in_valid = 1'b0;
  logic [7:0]   in_data  = 8'h00;
  logic         enc_done = 1'b0;
  logic [W-1:0] enc_c    = '0;
  logic         in_ready, enc_reset, enc_start, result_valid, busy, error;
  logic [W-1:0] message, e_key, n, result;

  int checks = 0;
  int fails  = 0;
  logic cmp_en = 1'b0;

  rsa_operand_loader #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n), .clear(clear), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .message(message), .e_key(e_key), .n(n),
    .enc_reset(enc_reset), .enc_start(enc_start), .enc_done(enc_done), .enc_c(enc_c),
    .result(result), .result_valid(result_valid), .busy(busy), .error(error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] modexp(input logic [W-1:0] b, input logic [W-1:0] e,
                                          input logic [W-1:0] m);
    logic [2*W-1:0] r, bb, mm;
    if (m == '0) return '0;
    mm = {{W{1'b0}}, m};
    bb = {{W{1'b0}}, b} % mm;
    r  = (2*W)'(1) % mm;
    for (int i = W - 1; i >= 0; i--) begin
      r = (r * r) % mm;
      if (e[i]) r = (r * bb) % mm;
    end
    return r[W-1:0];
  endfunction

  function automatic logic [3*W-1:0] rand_frame();
    logic [3*W-1:0] f;
    for (int i = 0; i < 3 * W / 32; i++) f[32*i +: 32] = $urandom();
    return f;
  endfunction

  // ---------------- reference model (frame level, cycle timestamps) ----------------
  logic [W-1:0] m_msg = '0, m_e = '0, m_n = '0, m_res = '0;
  logic m_rv = 1'b0, m_err = 1'b0, m_rst = 1'b1, m_start = 1'b0, m_busy = 1'b0, m_rdy = 1'b1;
  int   m_cnt = 0;
  int   m_age = 0;   // cycles since the frame completed: 0 reset pulse, 1 start pulse, 2.. waiting

  task automatic model_step();
    if (!reset_n) begin
      m_msg = '0; m_e = '0; m_n = '0; m_res = '0;
      m_rv = 1'b0; m_err = 1'b0; m_rst = 1'b1; m_start = 1'b0;
      m_busy = 1'b0; m_rdy = 1'b1; m_cnt = 0; m_age = 0;
    end else begin
      m_rst   = 1'b0;
      m_start = 1'b0;
      if (clear) begin
        m_cnt  = 0;
        m_busy = 1'b0;
        m_rst  = 1'b1;
      end else if (!m_busy) begin
        if (in_valid) begin
          if (m_cnt == 0) begin m_rv = 1'b0; m_err = 1'b0; end
          if (m_cnt < BYTES)          m_msg = (m_msg << 8) | W'(in_data);
          else if (m_cnt < 2 * BYTES) m_e   = (m_e << 8) | W'(in_data);
          else                        m_n   = (m_n << 8) | W'(in_data);
          m_cnt++;
          if (m_cnt == FRAME) begin
            m_cnt = 0; m_busy = 1'b1; m_age = 0; m_rst = 1'b1;
          end
        end
      end else begin
        if (m_age >= 2 && enc_done) begin
          m_res = enc_c; m_rv = 1'b1; m_busy = 1'b0;
        end else if (m_age - 2 == TO - 1) begin
          m_err = 1'b1; m_rst = 1'b1; m_busy = 1'b0;
        end else begin
          m_age++;
          if (m_age == 1) m_start = 1'b1;
        end
      end
      m_rdy = !m_busy;
    end
  endtask

  always @(posedge clk or negedge reset_n) model_step();

  // ---------------- encryptor stub ----------------
  int           stub_delay = 0;     // 0 = never answers
  logic         stub_force = 1'b0;
  logic [W-1:0] stub_force_val = '0;
  logic         noise_en = 1'b0;
  int           stub_cnt = 0;
  logic [W-1:0] stub_val = '0;

  task automatic stub_step();
    if (!reset_n) begin
      stub_cnt = 0;
      enc_done = 1'b0;
    end else begin
      enc_done = 1'b0;
      if (stub_cnt > 0) begin
        stub_cnt--;
        if (stub_cnt == 0) begin enc_done = 1'b1; enc_c = stub_val; end
      end else if (noise_en && !m_busy && $urandom_range(3) == 0) begin
        enc_done = 1'b1;
        enc_c = {$urandom(), $urandom(), $urandom(), $urandom()};
      end
      if (enc_start === 1'b1 && stub_delay > 0) begin
        stub_cnt = stub_delay;
        stub_val = stub_force ? stub_force_val : modexp(message, e_key, n);
      end
    end
  endtask

  always @(negedge clk) stub_step();

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("message", message, m_msg);
      chk("e_key", e_key, m_e);
      chk("n", n, m_n);
      chk("result", result, m_res);
      chk("result_valid", W'(result_valid), W'(m_rv));
      chk("error", W'(error), W'(m_err));
      chk("enc_reset", W'(enc_reset), W'(m_rst));
      chk("enc_start", W'(enc_start), W'(m_start));
      chk("busy", W'(busy), W'(m_busy));
      chk("in_ready", W'(in_ready), W'(m_rdy));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send_bytes(input logic [3*W-1:0] fr, input int nbytes, input int gap);
    int idx = 0;
    int budget = 3000;
    while (idx < nbytes && budget > 0) begin
      @(negedge clk);
      budget--;
      if ($urandom_range(99) < gap) begin
        in_valid = 1'b0;
      end else begin
        in_valid = 1'b1;
        in_data  = fr[3*W-1-8*idx -: 8];
        if (in_ready) idx++;
      end
    end
    chk("send_budget", W'(idx), W'(nbytes));
  endtask

  // returns in the first waiting cycle (start cycle + 1)
  task automatic finish_frame();
    @(negedge clk);
    in_valid = 1'b0;
    chk("lat_enc_reset", W'(enc_reset), W'(1'b1));
    chk("lat_no_start", W'(enc_start), W'(1'b0));
    chk("lat_not_ready", W'(in_ready), W'(1'b0));
    @(negedge clk);
    chk("lat_enc_start", W'(enc_start), W'(1'b1));
    chk("lat_reset_width", W'(enc_reset), W'(1'b0));
    @(negedge clk);
    chk("lat_start_width", W'(enc_start), W'(1'b0));
    chk("lat_busy", W'(busy), W'(1'b1));
  endtask

  task automatic wait_idle();
    int b = 0;
    while (busy !== 1'b0 && b < 200) begin
      @(negedge clk);
      b++;
    end
    chk("idle_budget", W'(b < 200), W'(1'b1));
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_enc_reset"}, W'(enc_reset), W'(1'b1));
    chk({tag, "_enc_start"}, W'(enc_start), W'(1'b0));
    chk({tag, "_busy"}, W'(busy), W'(1'b0));
    chk({tag, "_rv"}, W'(result_valid), W'(1'b0));
    chk({tag, "_error"}, W'(error), W'(1'b0));
    chk({tag, "_message"}, message, '0);
    chk({tag, "_e_key"}, e_key, '0);
    chk({tag, "_n"}, n, '0);
    chk({tag, "_result"}, result, '0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3*W-1:0] fr;
    #1 reset_n = 1'b0;
    #1 cmp_en = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    chk("model_pin_a", modexp(W'(32'h41), W'(32'h3), W'(32'hCA1)), W'(32'hBED));
    chk("model_pin_b", modexp(W'(32'd4), W'(32'd13), W'(32'd497)), W'(32'd445));
    reset_n = 1'b1;
    @(negedge clk);

    // known frame against the real-arithmetic stub
    stub_delay = 7;
    fr = {W'(32'h41), W'(32'h3), W'(32'hCA1)};
    send_bytes(fr, FRAME, 0);
    finish_frame();
    wait_idle();
    chk("t1_result", result, W'(32'hBED));
    chk("t1_rv", W'(result_valid), W'(1'b1));
    chk("t1_error", W'(error), W'(1'b0));
    chk("t1_message", message, W'(32'h41));
    chk("t1_e_key", e_key, W'(32'h3));
    chk("t1_n", n, W'(32'hCA1));

    // random frames with valid gaps, random latency and stray done pulses while idle
    noise_en = 1'b1;
    for (int k = 0; k < 5; k++) begin
      stub_delay = $urandom_range(1, TO - 1);
      send_bytes(rand_frame(), FRAME, 40);
      finish_frame();
      wait_idle();
      chk("rand_rv", W'(result_valid), W'(1'b1));
    end
    noise_en = 1'b0;

    // timeout: stub never answers
    stub_delay = 0;
    send_bytes(rand_frame(), FRAME, 20);
    finish_frame();
    repeat (TO - 1) @(negedge clk);
    chk("to_still_busy", W'(busy), W'(1'b1));
    chk("to_no_error_yet", W'(error), W'(1'b0));
    @(negedge clk);
    chk("to_error", W'(error), W'(1'b1));
    chk("to_enc_reset", W'(enc_reset), W'(1'b1));
    chk("to_in_ready", W'(in_ready), W'(1'b1));
    chk("to_rv", W'(result_valid), W'(1'b0));
    chk("to_busy", W'(busy), W'(1'b0));

    // done on the expiry cycle wins
    stub_delay = TO;
    stub_force = 1'b1;
    stub_force_val = W'(32'h1234);
    send_bytes(rand_frame(), FRAME, 10);
    finish_frame();
    repeat (TO) @(negedge clk);
    chk("race_result", result, W'(32'h1234));
    chk("race_rv", W'(result_valid), W'(1'b1));
    chk("race_error", W'(error), W'(1'b0));
    stub_force = 1'b0;

    // abort after 20 bytes; the byte offered alongside clear is dropped
    send_bytes(rand_frame(), 20, 30);
    @(negedge clk);
    clear = 1'b1;
    in_valid = 1'b1;
    in_data = 8'($urandom());
    @(negedge clk);
    clear = 1'b0;
    in_valid = 1'b0;
    chk("abort_enc_reset", W'(enc_reset), W'(1'b1));
    chk("abort_in_ready", W'(in_ready), W'(1'b1));
    stub_delay = 5;
    fr = rand_frame();
    send_bytes(fr, FRAME, 10);
    finish_frame();
    chk("abort_message", message, fr[3*W-1 -: W]);
    chk("abort_e_key", e_key, fr[2*W-1 -: W]);
    chk("abort_n", n, fr[W-1:0]);
    wait_idle();
    chk("abort_rv", W'(result_valid), W'(1'b1));

    // asynchronous reset in the middle of the wait
    stub_delay = 0;
    send_bytes(rand_frame(), FRAME, 0);
    finish_frame();
    repeat (5) @(negedge clk);
    #2 reset_n = 1'b0;
    #1 check_reset_values("areset");
    chk("areset_in_ready", W'(in_ready), W'(1'b1));
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    stub_delay = 9;
    fr = rand_frame();
    send_bytes(fr, FRAME, 25);
    finish_frame();
    wait_idle();
    chk("post_reset_rv", W'(result_valid), W'(1'b1));
    chk("post_reset_error", W'(error), W'(1'b0));
    chk("post_reset_result", result, modexp(fr[3*W-1 -: W], fr[2*W-1 -: W], fr[W-1:0]));

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
